spi_target_sync: RTL and testbench
==================================

Name: spi_target_sync

Overview:
- SPI target (slave) that runs entirely in the system clock domain; SCLK, CS_n and MOSI are treated as asynchronous inputs and oversampled.
- Provides a byte-stream interface to core logic: a one-entry TX holding buffer with valid/ready handshake, and an RX byte output with a valid strobe.
- Sits opposite spi_master on the board-level bus and replaces SCLK-clocked target logic wherever the core needs data in i_clk.

Parameters:
- DATA_W, 8, bits per frame, shifted MSB first.
- SYNC_STAGES, 2, synchronizer depth on i_sclk, i_cs_n and i_mosi (minimum 2).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_mode  in  2  {CPOL,CPHA}; latched on detected CS assertion.
- i_sclk  in  1  SPI clock, asynchronous.
- i_cs_n  in  1  chip select, active-low, asynchronous.
- i_mosi  in  1  serial data in, asynchronous.
- o_miso  out  1  serial data out.
- i_tx_data  in  DATA_W  next byte to transmit.
- i_tx_valid  in  1  i_tx_data valid.
- o_tx_ready  out  1  TX holding buffer empty.
- o_rx_data  out  DATA_W  last completed received byte.
- o_rx_valid  out  1  o_rx_data updated.
- o_busy  out  1  CS active (ACTIVE state).
- o_tx_underrun  out  1  one-cycle pulse: frame loaded with empty buffer.
- i_rx_ready  in  1  only with SPI_TARGET_RX_HS_EN.
- o_rx_overrun  out  1  only with SPI_TARGET_RX_HS_EN.

Behaviour:
- Reset (i_reset==0 at posedge i_clk): state IDLE, bit count 0, shift registers 0, TX buffer empty; o_miso=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_busy=0, o_tx_underrun=0, o_rx_overrun=0. Reset mid-frame aborts silently; the frame is not resumed after reset release until a fresh CS assertion.
- Synchronizers: SYNC_STAGES flops per input, followed by one history flop for edge detection. Edge events are single-cycle strobes.
- Leading edge = SCLK leaving the CPOL level; trailing edge = SCLK returning to it.
- FSM IDLE: on CS fall, latch i_mode, clear the bit count, go to ACTIVE. If CPHA=0, load the TX shift register from the buffer in the same cycle.
- FSM ACTIVE: on CS rise, go to IDLE and discard any partial frame (no o_rx_valid, bit count cleared; the buffer is kept unless already consumed).
- CPHA=0: sample MOSI on the leading edge and shift on the trailing edge. On the trailing edge that completes the frame, load the next byte instead of shifting.
- CPHA=1: shift on the leading edge, except that the first leading edge of each frame loads the buffer. Sample MOSI on the trailing edge.
- Load: if the buffer holds a byte, move it to the shift register and mark the buffer empty; o_tx_ready rises the following cycle. If the buffer is empty, load all zeros and pulse o_tx_underrun.
- Buffer write: accepted when i_tx_valid && o_tx_ready. A write in the same cycle as a load does not bypass into that load; it fills the buffer for the next frame.
- o_miso = shift register MSB while in ACTIVE, 0 in IDLE.
- RX: the sample that reaches bit DATA_W updates o_rx_data on the next clock edge, with o_rx_valid high for exactly 1 cycle; the bit count then wraps to 0. Back-to-back frames under one CS are supported.
- Bit count width is clog2(DATA_W)+1; it never exceeds DATA_W.
- Timing requirement: each SCLK half-period ≥ SYNC_STAGES+2 i_clk cycles. In CPHA=0, the master waits ≥ SYNC_STAGES+2 i_clk cycles after CS fall before the first edge, since MISO becomes valid SYNC_STAGES+1 cycles after CS falls.
- Simultaneous CS rise and SCLK edge in the same cycle: CS rise wins and the edge is ignored.

Optional Feature:
- Macro SPI_TARGET_RX_HS_EN.
- Defined: o_rx_valid is held until i_rx_ready is high on a clock edge. If a new frame completes while o_rx_valid is still high, o_rx_data is overwritten, o_rx_valid stays high, and o_rx_overrun pulses for 1 cycle.
- Undefined: i_rx_ready and o_rx_overrun are absent, and o_rx_valid is a fire-and-forget 1-cycle pulse.

Decomposition:
- Package spi_pkg: mode constants SPI_MODE0..3, the CPOL/CPHA bit indices, the FSM state enum {IDLE, ACTIVE}, and the default DATA_W.
- Sub-module spi_sync_edge: synchronizer plus rise/fall strobes, parameterized by SYNC_STAGES. Instantiated for i_sclk and i_cs_n; i_mosi uses the synchronizer path only.

Test Plan:
- Mode 0: buffer 0xA5, master sends 0x3C at i_clk/8 → o_rx_data=0x3C with a single o_rx_valid pulse; master receives 0xA5.
- Mode 3: two back-to-back frames under one CS with buffer refilled 0x11 then 0x22 → master sees 0x11, 0x22; two rx_valid pulses; no underrun.
- Underrun in mode 1: empty buffer at the first leading edge → MISO frame 0x00, o_tx_underrun one pulse, o_tx_ready stays 1.
- Abort in mode 2: CS rises after 5 bits → no o_rx_valid, o_busy falls; next frame 0x96 is received correctly.
- Reset mid-frame at bit 4: i_reset low for 1 cycle → all outputs at reset values; the next CS frame completes normally.
- SPI_TARGET_RX_HS_EN defined: hold i_rx_ready=0 across two frames 0x01, 0x02 → o_rx_overrun pulses once, o_rx_data=0x02, valid held until i_rx_ready=1.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode constants, FSM state type and default frame width
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // i_mode is {CPOL, CPHA}
  localparam int CPOL_IDX = 1;
  localparam int CPHA_IDX = 0;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_target_sync_if.sv
// rtl/spi_target_sync_if.sv - core-side byte stream bundle; RX handshake signals exist only with SPI_TARGET_RX_HS_EN
interface spi_target_sync_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) ();

  logic [DATA_W-1:0] i_tx_data;
  logic              i_tx_valid;
  logic              o_tx_ready;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_rx_valid;
  logic              o_tx_underrun;
`ifdef SPI_TARGET_RX_HS_EN
  logic              i_rx_ready;
  logic              o_rx_overrun;

  modport slave (
    input  i_tx_data, i_tx_valid, i_rx_ready,
    output o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun, o_rx_overrun
  );

  modport master (
    output i_tx_data, i_tx_valid, i_rx_ready,
    input  o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun, o_rx_overrun
  );
`else
  modport slave (
    input  i_tx_data, i_tx_valid,
    output o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun
  );

  modport master (
    output i_tx_data, i_tx_valid,
    input  o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun
  );
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with single-cycle rise/fall strobes
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign o_fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - i_clk-domain SPI target; define SPI_TARGET_RX_HS_EN for held rx_valid with overrun
module spi_target_sync
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_mode,
  input  logic             i_sclk,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_busy,
  spi_target_sync_if.slave core
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_state_e state_q, state_d;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tx_shift, rx_shift, tx_buf, rx_data_q;
  logic              tx_full, rx_valid_q, underrun_q;
  logic              start, abort, load, shift, sample, lead, trail, tx_write, rx_done;

  // CS reset level is "asserted" so a reset under a low CS never looks like a fresh CS fall
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_cs_n), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(i_sclk), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  // MOSI only needs the synchronizer; its depth matches SCLK so data and edge stay aligned
  always_ff @(posedge i_clk) begin
    if (!i_reset) mosi_sync <= '0;
    else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes; CS rise suppresses any coincident SCLK edge
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    sample  = 1'b0;
    lead    = mode_q[CPOL_IDX] ? sclk_fall : sclk_rise;
    trail   = mode_q[CPOL_IDX] ? sclk_rise : sclk_fall;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
          load    = ~i_mode[CPHA_IDX];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (!mode_q[CPHA_IDX]) begin
          // A trailing edge seen with a zero count can only follow a completed frame
          sample = lead;
          load   = trail && (cnt_q == '0);
          shift  = trail && (cnt_q != '0);
        end else begin
          load   = lead && (cnt_q == '0);
          shift  = lead && (cnt_q != '0);
          sample = trail;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_write = core.i_tx_valid & ~tx_full;
  assign rx_done  = (cnt_q == FULL_CNT);

  // Datapath: mode latch, bit counter, shift registers, TX holding buffer, RX output
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      mode_q     <= '0;
      cnt_q      <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
`ifdef SPI_TARGET_RX_HS_EN
      core.o_rx_overrun <= 1'b0;
`endif
    end else begin
      underrun_q <= 1'b0;
      if (start) mode_q <= i_mode;

      if (start || abort || rx_done) cnt_q <= '0;
      else if (sample)               cnt_q <= cnt_q + CNT_W'(1);

      if (sample) rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};

      if (load) begin
        tx_shift   <= tx_full ? tx_buf : '0;
        underrun_q <= ~tx_full;
        tx_full    <= 1'b0;
      end else if (shift) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // A write can only land while the buffer is empty, so it never races a real load
      if (tx_write) begin
        tx_buf  <= core.i_tx_data;
        tx_full <= 1'b1;
      end

      if (rx_done) rx_data_q <= rx_shift;
`ifdef SPI_TARGET_RX_HS_EN
      core.o_rx_overrun <= rx_done & rx_valid_q & ~core.i_rx_ready;
      if (rx_done)                rx_valid_q <= 1'b1;
      else if (core.i_rx_ready)   rx_valid_q <= 1'b0;
`else
      rx_valid_q <= rx_done;
`endif
    end
  end

  assign o_miso             = (state_q == ACTIVE) & tx_shift[DATA_W-1];
  assign o_busy             = (state_q == ACTIVE);
  assign core.o_tx_ready    = ~tx_full;
  assign core.o_rx_data     = rx_data_q;
  assign core.o_rx_valid    = rx_valid_q;
  assign core.o_tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// tb/tb_spi_target_sync.sv - directed bench for spi_target_sync; covers SPI_TARGET_RX_HS_EN when defined
module tb_spi_target_sync;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, busy;

  int checks = 0;
  int passed = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int rdy_low_cnt = 0;
  int ovr_cnt = 0;

  spi_target_sync_if #(.DATA_W(8)) core_if ();

  spi_target_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_mode(mode), .i_sclk(sclk),
    .i_cs_n(cs_n), .i_mosi(mosi), .o_miso(miso), .o_busy(busy), .core(core_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_if.o_rx_valid)    rxv_cnt++;
    if (core_if.o_tx_underrun) und_cnt++;
    if (!core_if.o_tx_ready)   rdy_low_cnt++;
`ifdef SPI_TARGET_RX_HS_EN
    if (core_if.o_rx_overrun)  ovr_cnt++;
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n;
    n = 0;
    while (!core_if.o_tx_ready && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (core_if.o_tx_ready !== 1'b1) $display("FAIL tx_write_wait: o_tx_ready=%b required 1", core_if.o_tx_ready);
    else passed++;
    core_if.i_tx_data  = d;
    core_if.i_tx_valid = 1'b1;
    tick(1);
    core_if.i_tx_valid = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    tick(HALF);
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF + 2);
  endtask

  task automatic xfer(input logic [1:0] m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = mo[7-i];
        tick(HALF);
        mi[7-i] = miso;
        sclk = ~m[1];
        tick(HALF);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = mo[7-i];
        tick(HALF);
        mi[7-i] = miso;
        sclk = m[1];
        tick(HALF);
      end
    end
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b required 0", miso); else passed++;
    checks++; if (core_if.o_tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b required 1", core_if.o_tx_ready); else passed++;
    checks++; if (core_if.o_rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", core_if.o_rx_data); else passed++;
    checks++; if (core_if.o_rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b required 0", core_if.o_rx_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    checks++; if (core_if.o_tx_underrun !== 1'b0) $display("FAIL reset_underrun: got %b required 0", core_if.o_tx_underrun); else passed++;
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int rxv0;
    tx_write(8'hA5);
    rxv0 = rxv_cnt;
    cs_low(SPI_MODE0);
    checks++; if (busy !== 1'b1) $display("FAIL mode0_busy: got %b required 1", busy); else passed++;
    xfer(SPI_MODE0, 8'h3C, 8, mi);
    cs_high();
    checks++; if (core_if.o_rx_data !== 8'h3C) $display("FAIL mode0_rx_data: got %h required 3c", core_if.o_rx_data); else passed++;
    checks++; if (rxv_cnt - rxv0 !== 1) $display("FAIL mode0_rx_valid_cycles: got %0d required 1", rxv_cnt - rxv0); else passed++;
    checks++; if (mi !== 8'hA5) $display("FAIL mode0_miso_byte: got %h required a5", mi); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    int rxv0, und0;
    tx_write(8'h11);
    rxv0 = rxv_cnt;
    und0 = und_cnt;
    cs_low(SPI_MODE3);
    xfer(SPI_MODE3, 8'h5A, 8, mi1);
    checks++; if (core_if.o_rx_data !== 8'h5A) $display("FAIL b2b_rx_first: got %h required 5a", core_if.o_rx_data); else passed++;
    tx_write(8'h22);
    xfer(SPI_MODE3, 8'hC3, 8, mi2);
    cs_high();
    checks++; if (mi1 !== 8'h11) $display("FAIL b2b_miso_first: got %h required 11", mi1); else passed++;
    checks++; if (mi2 !== 8'h22) $display("FAIL b2b_miso_second: got %h required 22", mi2); else passed++;
    checks++; if (core_if.o_rx_data !== 8'hC3) $display("FAIL b2b_rx_second: got %h required c3", core_if.o_rx_data); else passed++;
    checks++; if (rxv_cnt - rxv0 !== 2) $display("FAIL b2b_rx_valid_cycles: got %0d required 2", rxv_cnt - rxv0); else passed++;
    checks++; if (und_cnt - und0 !== 0) $display("FAIL b2b_underrun: got %0d required 0", und_cnt - und0); else passed++;
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    int und0, rdy0;
    und0 = und_cnt;
    rdy0 = rdy_low_cnt;
    cs_low(SPI_MODE1);
    xfer(SPI_MODE1, 8'hF0, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h00) $display("FAIL underrun_miso_byte: got %h required 00", mi); else passed++;
    checks++; if (und_cnt - und0 !== 1) $display("FAIL underrun_pulses: got %0d required 1", und_cnt - und0); else passed++;
    checks++; if (rdy_low_cnt - rdy0 !== 0) $display("FAIL underrun_tx_ready_low: got %0d required 0", rdy_low_cnt - rdy0); else passed++;
    checks++; if (core_if.o_rx_data !== 8'hF0) $display("FAIL underrun_rx_data: got %h required f0", core_if.o_rx_data); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rxv0;
    rxv0 = rxv_cnt;
    cs_low(SPI_MODE2);
    xfer(SPI_MODE2, 8'hFF, 5, mi);
    checks++; if (busy !== 1'b1) $display("FAIL abort_busy_mid: got %b required 1", busy); else passed++;
    cs_high();
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b required 0", busy); else passed++;
    checks++; if (rxv_cnt - rxv0 !== 0) $display("FAIL abort_rx_valid: got %0d required 0", rxv_cnt - rxv0); else passed++;
    checks++; if (core_if.o_rx_data !== 8'hF0) $display("FAIL abort_rx_kept: got %h required f0", core_if.o_rx_data); else passed++;
    cs_low(SPI_MODE2);
    xfer(SPI_MODE2, 8'h96, 8, mi);
    cs_high();
    checks++; if (core_if.o_rx_data !== 8'h96) $display("FAIL abort_next_rx: got %h required 96", core_if.o_rx_data); else passed++;
    checks++; if (rxv_cnt - rxv0 !== 1) $display("FAIL abort_next_valid: got %0d required 1", rxv_cnt - rxv0); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] mi;
    int rxv0;
    tx_write(8'h77);
    cs_low(SPI_MODE0);
    xfer(SPI_MODE0, 8'hFF, 4, mi);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    checks++; if (miso !== 1'b0) $display("FAIL midreset_miso: got %b required 0", miso); else passed++;
    checks++; if (core_if.o_tx_ready !== 1'b1) $display("FAIL midreset_tx_ready: got %b required 1", core_if.o_tx_ready); else passed++;
    checks++; if (core_if.o_rx_data !== 8'h00) $display("FAIL midreset_rx_data: got %h required 00", core_if.o_rx_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b required 0", busy); else passed++;
    rxv0 = rxv_cnt;
    xfer(SPI_MODE0, 8'hFF, 4, mi);
    checks++; if (rxv_cnt - rxv0 !== 0) $display("FAIL midreset_no_resume_valid: got %0d required 0", rxv_cnt - rxv0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_no_resume_busy: got %b required 0", busy); else passed++;
    cs_high();
    tx_write(8'h5C);
    rxv0 = rxv_cnt;
    cs_low(SPI_MODE0);
    xfer(SPI_MODE0, 8'h81, 8, mi);
    cs_high();
    checks++; if (core_if.o_rx_data !== 8'h81) $display("FAIL midreset_next_rx: got %h required 81", core_if.o_rx_data); else passed++;
    checks++; if (mi !== 8'h5C) $display("FAIL midreset_next_miso: got %h required 5c", mi); else passed++;
    checks++; if (rxv_cnt - rxv0 !== 1) $display("FAIL midreset_next_valid: got %0d required 1", rxv_cnt - rxv0); else passed++;
  endtask

`ifdef SPI_TARGET_RX_HS_EN
  task automatic test_rx_handshake();
    logic [7:0] mi;
    int ovr0;
    ovr0 = ovr_cnt;
    core_if.i_rx_ready = 1'b0;
    cs_low(SPI_MODE0);
    xfer(SPI_MODE0, 8'h01, 8, mi);
    xfer(SPI_MODE0, 8'h02, 8, mi);
    cs_high();
    checks++; if (core_if.o_rx_valid !== 1'b1) $display("FAIL hs_valid_held: got %b required 1", core_if.o_rx_valid); else passed++;
    checks++; if (core_if.o_rx_data !== 8'h02) $display("FAIL hs_rx_data: got %h required 02", core_if.o_rx_data); else passed++;
    checks++; if (ovr_cnt - ovr0 !== 1) $display("FAIL hs_overrun_pulses: got %0d required 1", ovr_cnt - ovr0); else passed++;
    core_if.i_rx_ready = 1'b1;
    tick(1);
    checks++; if (core_if.o_rx_valid !== 1'b0) $display("FAIL hs_valid_release: got %b required 0", core_if.o_rx_valid); else passed++;
  endtask
`endif

  initial begin
    core_if.i_tx_data  = 8'h00;
    core_if.i_tx_valid = 1'b0;
`ifdef SPI_TARGET_RX_HS_EN
    core_if.i_rx_ready = 1'b1;
`endif
    test_reset();
    test_mode0();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
`ifdef SPI_TARGET_RX_HS_EN
    test_rx_handshake();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
